// File: rtl/instr_exec_unit.sv
// rtl/instr_exec_unit.sv - two-stage fetch/execute unit walking a range of instruction register entries
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, start_ptr, num_instr command: walk num_instr entries from start_ptr (mod 2**PTR_W)
//   read_pointer               entry index presented to the instruction register
//   instruction_word, valid    {opcode[3:0], operand_a, operand_b} and loaded flag for read_pointer
//   result, result_ptr,
//   result_err, result_valid,
//   result_ready               ready/valid result output (one per valid entry)
//   busy                       high while a command is in RUN or DRAIN
//   done                       one-cycle pulse when a command completes
//
// Opcodes: 0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD; others undefined.
module instr_exec_unit #(
    parameter int OP_W  = 32,
    parameter int PTR_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [PTR_W-1:0]    start_ptr,
    input  logic [PTR_W:0]      num_instr,
    output logic [PTR_W-1:0]    read_pointer,
    input  logic [2*OP_W+3:0]   instruction_word,
    input  logic                valid,
    output logic [2*OP_W-1:0]   result,
    output logic [PTR_W-1:0]    result_ptr,
    output logic                result_err,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                busy,
    output logic                done
);

    localparam logic [3:0] OP_ZERO  = 4'd0;
    localparam logic [3:0] OP_PASSA = 4'd1;
    localparam logic [3:0] OP_PASSB = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MULT  = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_MOD   = 4'd7;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state, state_nx;
    logic [PTR_W:0]     remaining, remaining_nx;
    logic [PTR_W-1:0]   ptr_nx;
    logic               done_nx;

    // Stage 1: s1_occ marks any issued entry (bubbles included, so DRAIN
    // waits for them); s1_vld marks entries that will produce a result.
    logic               s1_occ;
    logic               s1_vld;
    logic [2*OP_W+3:0]  s1_word;
    logic [PTR_W-1:0]   s1_ptr;

    logic               stall;
    logic               issue;

    assign stall = result_valid && !result_ready;
    assign issue = (state == RUN) && !stall;
    assign busy  = (state != IDLE);

    always_comb begin
        state_nx     = state;
        ptr_nx       = read_pointer;
        remaining_nx = remaining;
        done_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_instr != '0) begin
                        state_nx     = RUN;
                        ptr_nx       = start_ptr;
                        remaining_nx = num_instr;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    ptr_nx       = read_pointer + 1'b1;
                    remaining_nx = remaining - 1'b1;
                    if (remaining == 1) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Output register empties at this edge if it is empty or being accepted.
                if (!s1_occ && (!result_valid || result_ready)) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            read_pointer <= '0;
            remaining    <= '0;
            done         <= 1'b0;
        end else begin
            state        <= state_nx;
            read_pointer <= ptr_nx;
            remaining    <= remaining_nx;
            done         <= done_nx;
        end
    end

    // Execute: combinational from stage 1.
    logic [3:0]                op;
    logic [OP_W-1:0]           op_a, op_b;
    logic signed [2*OP_W-1:0]  ax, bx, bdiv, ex_res;
    logic                      ex_err;

    assign op   = s1_word[2*OP_W+3 -: 4];
    assign op_a = s1_word[2*OP_W-1 -: OP_W];
    assign op_b = s1_word[OP_W-1:0];
    assign ax   = {{OP_W{op_a[OP_W-1]}}, op_a};
    assign bx   = {{OP_W{op_b[OP_W-1]}}, op_b};

    // Divisor forced to 1 on b==0 so the divider never sees zero; the
    // result is overridden to 0 with err in that case anyway. Dividing at
    // 2*OP_W keeps MIN/-1 exact.
    assign bdiv = (op_b == '0) ? {{(2*OP_W-1){1'b0}}, 1'b1} : bx;

    always_comb begin
        ex_res = '0;
        ex_err = 1'b0;
        case (op)
            OP_ZERO:  ex_res = '0;
            OP_PASSA: ex_res = ax;
            OP_PASSB: ex_res = bx;
            OP_ADD:   ex_res = ax + bx;
            OP_SUB:   ex_res = ax - bx;
            OP_MULT:  ex_res = ax * bx;
            OP_DIV: begin
                if (op_b == '0) ex_err = 1'b1;
                else            ex_res = ax / bdiv;
            end
            OP_MOD: begin
                if (op_b == '0) ex_err = 1'b1;
                else            ex_res = ax % bdiv;
            end
            default: ex_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_occ       <= 1'b0;
            s1_vld       <= 1'b0;
            s1_word      <= '0;
            s1_ptr       <= '0;
            result       <= '0;
            result_ptr   <= '0;
            result_err   <= 1'b0;
            result_valid <= 1'b0;
        end else if (!stall) begin
            s1_occ <= issue;
            s1_vld <= issue && valid;
            if (issue) begin
                s1_word <= instruction_word;
                s1_ptr  <= read_pointer;
            end
            result_valid <= s1_vld;
            if (s1_vld) begin
                result     <= ex_res;
                result_ptr <= s1_ptr;
                result_err <= ex_err;
            end
        end
    end

endmodule

// File: tb/tb_instr_exec_unit.sv
// tb/tb_instr_exec_unit.sv - self-checking bench for instr_exec_unit
module tb_instr_exec_unit;

    localparam int OP_W  = 32;
    localparam int PTR_W = 5;

    localparam logic [3:0] ZERO = 4'd0, PASSA = 4'd1, PASSB = 4'd2, ADD = 4'd3,
                           SUB = 4'd4, MULT = 4'd5, DIV = 4'd6, MOD = 4'd7;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [PTR_W-1:0]    start_ptr;
    logic [PTR_W:0]      num_instr;
    logic [PTR_W-1:0]    read_pointer;
    logic [2*OP_W+3:0]   instruction_word;
    logic                valid;
    logic [2*OP_W-1:0]   result;
    logic [PTR_W-1:0]    result_ptr;
    logic                result_err;
    logic                result_valid;
    logic                result_ready;
    logic                busy;
    logic                done;

    instr_exec_unit #(.OP_W(OP_W), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .start_ptr(start_ptr),
        .num_instr(num_instr), .read_pointer(read_pointer),
        .instruction_word(instruction_word), .valid(valid),
        .result(result), .result_ptr(result_ptr), .result_err(result_err),
        .result_valid(result_valid), .result_ready(result_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Instruction register model
    logic [3:0]      mem_op [32];
    logic [OP_W-1:0] mem_a  [32];
    logic [OP_W-1:0] mem_b  [32];
    logic            mem_v  [32];

    assign instruction_word = {mem_op[read_pointer], mem_a[read_pointer], mem_b[read_pointer]};
    assign valid            = mem_v[read_pointer];

    typedef struct {
        logic [3:0] op;
        int         a;
        int         b;
        longint     res;
        bit         err;
    } vec_t;

    typedef struct {
        longint res;
        int     ptr;
        bit     err;
    } exp_t;

    vec_t tv [8];
    exp_t exp_q [$];

    int checks   = 0;
    int failures = 0;

    int unsigned cyc = 0;
    int          ready_mode = 0;
    int          done_cnt = 0;
    bit          first_seen = 0;
    int unsigned first_cyc = 0;
    int unsigned start_cyc = 0;

    bit                 prev_stall = 0;
    logic [2*OP_W-1:0]  prev_res;
    logic [PTR_W-1:0]   prev_ptr;
    logic               prev_err;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    task automatic push_exp(input longint r, input int p, input bit e);
        exp_t x;
        x.res = r;
        x.ptr = p;
        x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic set_mem(input int i, input logic [3:0] op, input int a, input int b, input bit v);
        mem_op[i] = op;
        mem_a[i]  = a;
        mem_b[i]  = b;
        mem_v[i]  = v;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       result_ready = 1'b1;
            1:       result_ready = (cyc % 3 == 2);
            default: result_ready = 1'b0;
        endcase
    end

    // Output monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_hold", result_valid, 1);
                chk("stall_result_hold", result, prev_res);
                chk("stall_ptr_hold", result_ptr, prev_ptr);
                chk("stall_err_hold", result_err, prev_err);
            end
            if (done) begin
                done_cnt++;
                chk("busy_low_at_done", busy, 0);
            end
            if (result_valid && !first_seen) begin
                first_seen = 1;
                first_cyc  = cyc;
            end
            if (result_valid && result_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result_ptr", result_ptr, -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", $signed(result), e.res);
                    chk("result_ptr", result_ptr, e.ptr);
                    chk("result_err", result_err, e.err);
                end
            end
            prev_stall = result_valid && !result_ready;
            prev_res   = result;
            prev_ptr   = result_ptr;
            prev_err   = result_err;
        end
    end

    task automatic run(input int sp, input int n, input int mode, input bit check_lat);
        ready_mode = mode;
        done_cnt   = 0;
        first_seen = 0;
        @(posedge clk); #1;
        start     = 1'b1;
        start_ptr = sp[PTR_W-1:0];
        num_instr = n[PTR_W:0];
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 300 && done_cnt == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        #1;
        chk("done_once", done_cnt, 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("busy_idle", busy, 0);
        if (check_lat) chk("first_result_latency", longint'(first_cyc) - longint'(start_cyc) - 1, 2);
    endtask

    initial begin
        tv[0] = '{ADD,   5,   7,  12, 0};
        tv[1] = '{SUB,   3,  10,  -7, 0};
        tv[2] = '{MULT, -4,   6, -24, 0};
        tv[3] = '{PASSB, 0,   9,   9, 0};
        tv[4] = '{DIV, 100,   0,   0, 1};
        tv[5] = '{MOD,  -7,   2,  -1, 0};
        tv[6] = '{4'hF,  1,   1,   0, 1};
        tv[7] = '{DIV, -20,   3,  -6, 0};

        for (int i = 0; i < 32; i++) set_mem(i, ZERO, 0, 0, 0);
        for (int i = 0; i < 8; i++) set_mem(i, tv[i].op, tv[i].a, tv[i].b, 1);
        set_mem(30, PASSA, -3, 5, 1);
        set_mem(31, ADD,    1, 2, 1);

        reset        = 1'b1;
        start        = 1'b0;
        start_ptr    = '0;
        num_instr    = '0;
        result_ready = 1'b0;
        #2;
        chk("rst_read_pointer", read_pointer, 0);
        chk("rst_result", result, 0);
        chk("rst_result_ptr", result_ptr, 0);
        chk("rst_result_err", result_err, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Basic run, ready held high
        for (int i = 0; i < 4; i++) push_exp(tv[i].res, i, tv[i].err);
        run(0, 4, 0, 1);

        // Same run with ready pattern 0,0,1
        for (int i = 0; i < 4; i++) push_exp(tv[i].res, i, tv[i].err);
        run(0, 4, 1, 1);

        // Divide/mod corner cases and undefined opcode
        for (int i = 4; i < 8; i++) push_exp(tv[i].res, i, tv[i].err);
        run(4, 4, 0, 1);

        // Pointer wrap 30,31,0,1
        push_exp(-3, 30, 0);
        push_exp(3, 31, 0);
        push_exp(12, 0, 0);
        push_exp(-7, 1, 0);
        run(30, 4, 0, 1);

        // Bubbles at entries 1 and 2
        mem_v[1] = 0;
        mem_v[2] = 0;
        push_exp(12, 0, 0);
        push_exp(9, 3, 0);
        run(0, 4, 1, 1);
        chk("rp_after_bubble_run", read_pointer, 4);

        // num_instr = 0: done only, no read
        run(7, 0, 0, 0);
        chk("rp_unchanged_n0", read_pointer, 4);
        mem_v[1] = 1;
        mem_v[2] = 1;

        // Reset while a result is pending
        ready_mode = 2;
        for (int i = 0; i < 4; i++) push_exp(tv[i].res, i, tv[i].err);
        @(posedge clk); #1;
        start     = 1'b1;
        start_ptr = '0;
        num_instr = 6'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20 && !result_valid; k++) @(negedge clk);
        chk("valid_before_reset", result_valid, 1);
        chk("busy_before_reset", busy, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_read_pointer", read_pointer, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_result_ptr", result_ptr, 0);
        chk("mid_rst_result_err", result_err, 0);
        chk("mid_rst_result_valid", result_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 4; i++) push_exp(tv[i].res, i, tv[i].err);
        run(0, 4, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
